// File: rtl/rdata_fifo_reader.sv
// ----------------------------------------------------------------------------
// rdata_fifo_reader
//
// Purpose:
//   Read-side drain engine for a read-data FIFO that has one cycle of read
//   latency and no output register. It issues read enables, lands the
//   returned words in a 2-entry skid buffer and presents them as a
//   valid/ready pixel stream. Internal pixel/line counters track the head
//   beat and supply start-of-frame, end-of-line and end-of-frame markers.
//
// Ports:
//   rd_clk         in   clock, shared with the FIFO read port
//   rd_rst_n       in   asynchronous active-low reset
//   fifo_rd_en     out  FIFO read enable
//   fifo_rd_data   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_empty  in   FIFO empty flag
//   frame_sync     in   one-cycle pulse, realigns counters to frame start
//   m_valid        out  stream valid
//   m_ready        in   stream ready
//   m_data         out  pixel (head of the skid buffer)
//   m_sof          out  current beat is pixel (0,0)
//   m_eol          out  current beat is last pixel of its line
//   m_eof          out  current beat is last pixel of the frame
//   frame_done     out  one-cycle pulse after the last frame pixel is taken
//   err_misalign   out  sticky: frame_sync arrived mid-frame
// ----------------------------------------------------------------------------
module rdata_fifo_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 720,
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 10
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic                  frame_sync,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_sof,
    output logic                  m_eol,
    output logic                  m_eof,
    output logic                  frame_done,
    output logic                  err_misalign
);

    localparam logic [X_WIDTH-1:0] X_LAST = X_WIDTH'(H_ACTIVE - 1);
    localparam logic [Y_WIDTH-1:0] Y_LAST = Y_WIDTH'(V_ACTIVE - 1);

    // Skid buffer state
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [1:0]            occ_q, occ_d;
    logic                  head_q, tail_q;
    logic                  pend_q;

    // Position of the head beat inside the frame
    logic [X_WIDTH-1:0]    x_q, x_d;
    logic [Y_WIDTH-1:0]    y_q, y_d;

    logic                  frame_done_q;
    logic                  err_q, err_d;

    logic                  fire;
    logic                  at_eol;
    logic                  at_eof;
    logic [2:0]            inflight;

    assign m_valid = (occ_q != 2'd0);
    assign fire    = m_valid & m_ready;
    assign m_data  = buf_q[head_q];

    // Words already committed to the buffer: stored entries plus the read
    // whose data lands at the coming edge.
    assign inflight = {1'b0, occ_q} + {2'b00, pend_q};

    // Issue only when the word would still fit after this cycle's pop. The
    // m_ready -> fifo_rd_en path is what lets the stream run at full rate.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rd_rst_n && !fifo_rd_empty && (inflight <= (3'd1 + {2'b00, fire}))) begin
            fifo_rd_en = 1'b1;
        end
    end

    // Occupancy never leaves 0..2 because the issue rule above bounds it.
    assign occ_d = occ_q + {1'b0, pend_q} - {1'b0, fire};

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            occ_q  <= 2'd0;
            pend_q <= 1'b0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            pend_q <= fifo_rd_en;
            if (pend_q) begin
                tail_q <= ~tail_q;
            end
            if (fire) begin
                head_q <= ~head_q;
            end
        end
    end

    // One register per buffer entry; the entry under the tail pointer takes
    // the returning FIFO word.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_buf
            always_ff @(posedge rd_clk or negedge rd_rst_n) begin
                if (!rd_rst_n) begin
                    buf_q[gi] <= '0;
                end else if (pend_q && (tail_q == 1'(gi))) begin
                    buf_q[gi] <= fifo_rd_data;
                end
            end
        end
    endgenerate

    // Counter update: frame_sync wins over an accepted beat; the beat is
    // still consumed by the buffer logic above.
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        err_d = err_q;
        if (frame_sync) begin
            x_d = '0;
            y_d = '0;
            if ((x_q != '0) || (y_q != '0)) begin
                err_d = 1'b1;
            end
        end else if (fire) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + Y_WIDTH'(1);
                end
            end else begin
                x_d = x_q + X_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            err_q        <= err_d;
            frame_done_q <= fire & at_eof;
        end
    end

    assign at_eol = (x_q == X_LAST);
    assign at_eof = at_eol & (y_q == Y_LAST);

    assign m_sof        = m_valid & (x_q == '0) & (y_q == '0);
    assign m_eol        = m_valid & at_eol;
    assign m_eof        = m_valid & at_eof;
    assign frame_done   = frame_done_q;
    assign err_misalign = err_q;

endmodule

// File: tb/tb_rdata_fifo_reader.sv
module tb_rdata_fifo_reader;

    localparam int DW    = 16;
    localparam int H     = 4;
    localparam int V     = 2;
    localparam int FRAME = H * V;

    logic          rd_clk = 1'b0;
    logic          rd_rst_n = 1'b0;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data = '0;
    logic          fifo_rd_empty = 1'b1;
    logic          frame_sync = 1'b0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_sof, m_eol, m_eof;
    logic          frame_done;
    logic          err_misalign;

    rdata_fifo_reader #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .X_WIDTH    (2),
        .Y_WIDTH    (1)
    ) dut (
        .rd_clk        (rd_clk),
        .rd_rst_n      (rd_rst_n),
        .fifo_rd_en    (fifo_rd_en),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .frame_sync    (frame_sync),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_sof         (m_sof),
        .m_eol         (m_eol),
        .m_eof         (m_eof),
        .frame_done    (frame_done),
        .err_misalign  (err_misalign)
    );

    always #5 rd_clk = ~rd_clk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] fifo_q [$];   // words waiting in the modelled FIFO
    logic [DW-1:0] exp_q  [$];   // scoreboard: expected stream order
    bit            prod_done = 1'b0;

    function automatic void chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endfunction

    // FIFO model: one cycle read latency, registered empty flag.
    logic [DW-1:0] pop_word;
    always @(posedge rd_clk) begin
        if (fifo_rd_en && (fifo_q.size() > 0)) begin
            pop_word = fifo_q.pop_front();
            fifo_rd_data <= pop_word;
        end
        fifo_rd_empty <= (fifo_q.size() == 0);
    end

    // Monitor / reference model. beat_cnt is the linear index of the head
    // beat inside the frame; markers derive from it by div/mod.
    int            beat_cnt = 0;
    bit            exp_err = 1'b0;
    bit            exp_fd = 1'b0;
    int            issued = 0;
    int            accepted = 0;
    bit            stall_prev = 1'b0;
    logic [DW-1:0] snap_data;
    logic [2:0]    snap_mk;

    always @(negedge rd_clk) begin
        bit            f;
        bit            e_eof;
        int            ex, ey;
        logic [DW-1:0] e;
        if (!rd_rst_n) begin
            beat_cnt   = 0;
            exp_err    = 1'b0;
            exp_fd     = 1'b0;
            issued     = 0;
            accepted   = 0;
            stall_prev = 1'b0;
        end else begin
            f = m_valid && m_ready;
            chk("frame_done", frame_done, exp_fd);
            chk("err_misalign", err_misalign, exp_err);
            chk("rd_en_while_empty", fifo_rd_en & fifo_rd_empty, 0);
            chk("occupancy_le2", (issued - accepted) <= 2, 1);
            if (stall_prev) begin
                chk("hold_data", m_data, snap_data);
                chk("hold_markers", {m_sof, m_eol, m_eof}, snap_mk);
                chk("hold_valid", m_valid, 1);
            end
            e_eof = 1'b0;
            if (f) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", m_data, 'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", m_data, e);
                end
                ex    = beat_cnt % H;
                ey    = beat_cnt / H;
                e_eof = (beat_cnt == FRAME - 1);
                chk("sof", m_sof, (ex == 0) && (ey == 0));
                chk("eol", m_eol, ex == H - 1);
                chk("eof", m_eof, e_eof);
            end
            exp_fd     = e_eof;
            stall_prev = m_valid && !m_ready && !frame_sync;
            snap_data  = m_data;
            snap_mk    = {m_sof, m_eol, m_eof};
            if (frame_sync) begin
                if (beat_cnt != 0) exp_err = 1'b1;
                beat_cnt = 0;
            end else if (f) begin
                beat_cnt = (beat_cnt + 1) % FRAME;
            end
            if (fifo_rd_en) issued++;
            if (f) accepted++;
        end
    end

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        exp_q.push_back(d);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int g = 0;
        while ((exp_q.size() != 0) && (g < budget)) begin
            cyc(1);
            g++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    initial begin
        int  n;
        int  g;
        bit  found;

        // ---------------- reset with a non-empty FIFO ----------------
        for (int i = 1; i <= 8; i++) push(DW'(i));
        cyc(3);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_markers", {m_sof, m_eol, m_eof}, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err", err_misalign, 0);
        rd_rst_n = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge rd_clk);
            if (fifo_rd_en) found = 1'b1;
        end
        chk("first_rd_en_seen", found, 1);
        @(negedge rd_clk);
        chk("latency_t1_valid", m_valid, 0);
        @(negedge rd_clk);
        chk("latency_t2_valid", m_valid, 1);
        chk("latency_t2_sof", m_sof, 1);

        // ---------------- full-rate streaming ----------------
        @(posedge rd_clk); #1;
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge rd_clk);
            chk("stream_no_bubble", m_valid, 1);
        end
        wait_drain("stream_drain", 50);
        cyc(3);

        // ---------------- underflow mid-line ----------------
        push(16'h0101); push(16'h0102); push(16'h0103);
        cyc(8);
        chk("underflow_gap_valid", m_valid, 0);
        for (int i = 4; i <= 8; i++) push(DW'(16'h0100 + i));
        wait_drain("underflow_drain", 50);
        cyc(3);

        // ---------------- frame_sync at frame start ----------------
        m_ready    = 1'b0;
        frame_sync = 1'b1;
        cyc(1);
        frame_sync = 1'b0;
        cyc(2);
        chk("aligned_sync_no_err", err_misalign, 0);

        // ---------------- misaligned frame_sync after 5 beats ----------------
        for (int i = 0; i < 10; i++) push(DW'(16'h0200 + i));
        m_ready = 1'b1;
        n = 0;
        g = 0;
        while ((n < 5) && (g < 100)) begin
            @(negedge rd_clk);
            if (m_valid && m_ready) n++;
            g++;
        end
        chk("five_beats_seen", n, 5);
        @(posedge rd_clk); #1;
        m_ready    = 1'b0;
        frame_sync = 1'b1;
        cyc(1);
        frame_sync = 1'b0;
        cyc(2);
        chk("misalign_err_set", err_misalign, 1);
        chk("realigned_sof", m_sof, 1);
        m_ready = 1'b1;
        wait_drain("misalign_drain", 50);
        cyc(3);
        chk("misalign_err_sticky", err_misalign, 1);

        // ---------------- mid-frame reset ----------------
        for (int i = 0; i < 6; i++) push(DW'(16'h0300 + i));
        cyc(3);
        rd_rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", fifo_rd_en, 0);
        chk("midrst_valid", m_valid, 0);
        chk("midrst_data", m_data, 0);
        chk("midrst_markers", {m_sof, m_eol, m_eof}, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_err", err_misalign, 0);
        cyc(1);
        fifo_q.delete();
        exp_q.delete();
        cyc(2);
        rd_rst_n = 1'b1;
        cyc(2);

        // ---------------- random backpressure, 1000 words ----------------
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    push(DW'($urandom));
                    cyc(1);
                    if ($urandom_range(0, 7) == 0) cyc($urandom_range(1, 6));
                end
                prod_done = 1'b1;
            end
            begin
                int guard = 0;
                while (!(prod_done && (exp_q.size() == 0)) && (guard < 20000)) begin
                    m_ready = 1'($urandom_range(0, 1));
                    cyc(1);
                    guard++;
                end
                chk("random_finished_in_budget", guard < 20000, 1);
            end
        join
        m_ready = 1'b1;
        wait_drain("random_drain", 50);
        cyc(4);
        chk("fifo_model_empty", fifo_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
